// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int DEFAULT_MAX_BURST = 64;

    function automatic int beat_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TX-FIFO-side stream signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           i_req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] i_req_data;
    logic [NUM_REQ-1:0]           i_req_last;
    logic [NUM_REQ-1:0]           o_req_ready;
    logic                         o_tx_valid;
    logic [DATA_BITS-1:0]         o_tx_data;
    logic                         i_tx_ready;

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
        output o_req_ready, o_tx_valid, o_tx_data
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_ready,
        input  o_req_ready, o_tx_valid, o_tx_data
    );
endinterface

// File: rtl/rr_priority_select.sv
// Combinational rotating priority encoder: picks the first set request
// strictly after i_last_idx, wrapping around modulo NUM_REQ.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_idx,
    output logic [IDX_W-1:0]   o_sel,
    output logic               o_any_req
);
    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    // Scan every position once, starting one past the previous winner.
    always_comb begin
        logic [IDX_W-1:0] v_idx;
        w_sel   = '0;
        w_found = 1'b0;
        v_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = IDX_W'((int'(i_last_idx) + k) % NUM_REQ);
            if (!w_found && i_req[v_idx]) begin
                w_sel   = v_idx;
                w_found = 1'b1;
            end else begin
                w_sel = w_sel;
            end
        end
    end

    assign o_sel     = w_sel;
    assign o_any_req = w_found;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX FIFO write port among
// NUM_REQ byte-stream requesters, with a per-grant beat limit.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic               clk,
    input  logic               n_rst,
    uart_tx_arbiter_if.slave   io_bus,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_busy,
    output logic               o_forced_release
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = beat_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e           r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]     r_last_idx, w_last_idx_nxt;
    logic [CNT_W-1:0]     r_beat_cnt, w_beat_cnt_nxt;
    logic                 r_forced, w_forced_nxt;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_any_req;
    logic                 w_handshake;
    logic [DATA_BITS-1:0] w_data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   w_req_ready;
    logic                 w_tx_valid;
    logic [DATA_BITS-1:0] w_tx_data;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_sel (
        .i_req      (io_bus.i_req_valid),
        .i_last_idx (r_last_idx),
        .o_sel      (w_sel),
        .o_any_req  (w_any_req)
    );

    // Split the flat requester data bus into one byte per lane.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_data_arr[k] = io_bus.i_req_data[k*DATA_BITS +: DATA_BITS];
        end
    end

    // Next-state, beat counting and the combinational grant data path.
    // While granted, r_last_idx is the granted requester's index.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_idx_nxt = r_last_idx;
        w_beat_cnt_nxt = r_beat_cnt;
        w_forced_nxt   = 1'b0;
        w_req_ready    = '0;
        w_tx_valid     = 1'b0;
        w_tx_data      = '0;
        w_handshake    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt    = ARB_GRANT;
                    w_grant_nxt    = ONE_HOT_0 << w_sel;
                    w_last_idx_nxt = w_sel;
                    w_beat_cnt_nxt = '0;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                w_tx_valid              = io_bus.i_req_valid[r_last_idx];
                w_tx_data               = w_data_arr[r_last_idx];
                w_req_ready[r_last_idx] = io_bus.i_tx_ready;
                w_handshake             = w_tx_valid && io_bus.i_tx_ready;
                if (w_handshake) begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_ONE;
                    if (io_bus.i_req_last[r_last_idx]) begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                    end else if ((r_beat_cnt + CNT_ONE) == CNT_LIMIT) begin
                        w_state_nxt  = ARB_IDLE;
                        w_grant_nxt  = '0;
                        w_forced_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ARB_GRANT;
                    end
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, grant, round-robin pointer and beat counter registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_last_idx <= IDX_LAST;
            r_beat_cnt <= '0;
            r_forced   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_forced   <= w_forced_nxt;
        end
    end

    assign io_bus.o_req_ready = w_req_ready;
    assign io_bus.o_tx_valid  = w_tx_valid;
    assign io_bus.o_tx_data   = w_tx_data;
    assign o_grant            = r_grant;
    assign o_busy             = (r_state == ARB_GRANT);
    assign o_forced_release   = r_forced;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized run scored against a transaction-level reference model.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DB = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [NR-1:0] grant;
    logic          busy;
    logic          frc;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .DATA_BITS (DB),
        .MAX_BURST (MB)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .io_bus           (bus),
        .o_grant          (grant),
        .o_busy           (busy),
        .o_forced_release (frc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        rdy;
        logic [3:0]  e_grant;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rdy;
        logic        e_busy;
        logic        e_frc;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                                input logic [31:0] d, input logic rdy, input logic [3:0] eg,
                                input logic etxv, input logic [7:0] etxd, input logic [3:0] erdy,
                                input logic ebusy, input logic efrc);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.d = d; t.rdy = rdy;
        t.e_grant = eg; t.e_txv = etxv; t.e_txd = etxd; t.e_rdy = erdy;
        t.e_busy = ebusy; t.e_frc = efrc;
        return t;
    endfunction

    // Drive one cycle of inputs, check outputs on the falling edge.
    task automatic apply(input vec_t t, input string tag);
        n_rst            = t.rst;
        bus.i_req_valid  = t.v;
        bus.i_req_last   = t.l;
        bus.i_req_data   = t.d;
        bus.i_tx_ready   = t.rdy;
        @(negedge clk);
        chk({tag, ".grant"}, 32'(grant), 32'(t.e_grant));
        chk({tag, ".tx_valid"}, 32'(bus.o_tx_valid), 32'(t.e_txv));
        chk({tag, ".req_ready"}, 32'(bus.o_req_ready), 32'(t.e_rdy));
        chk({tag, ".busy"}, 32'(busy), 32'(t.e_busy));
        chk({tag, ".forced"}, 32'(frc), 32'(t.e_frc));
        if (t.e_txv) chk({tag, ".tx_data"}, 32'(bus.o_tx_data), 32'(t.e_txd));
        @(posedge clk);
        #1;
    endtask

    // Random-phase state: requester drivers and the reference model.
    logic [7:0]    cur_d [NR];
    bit            cur_v [NR];
    bit            cur_l [NR];
    int            rem   [NR];
    int            m_g, m_last, m_cnt;
    bit            m_frc;

    initial begin
        logic [3:0] one;
        logic [3:0] eg, erdy;
        bit         etxv, hs, found;
        int         idx, g;

        one = 4'b0001;
        n_rst = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_last  = '0;
        bus.i_req_data  = '0;
        bus.i_tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Requester 2 alone, three-byte packet.
        tbl[0]  = mk(1'b1, 4'b0100, 4'b0000, 32'h00410000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 4'b0100, 4'b0000, 32'h00410000, 1'b1, 4'b0100, 1'b1, 8'h41, 4'b0100, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 4'b0100, 4'b0000, 32'h00420000, 1'b1, 4'b0100, 1'b1, 8'h42, 4'b0100, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 4'b0100, 4'b0100, 32'h00430000, 1'b1, 4'b0100, 1'b1, 8'h43, 4'b0100, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        // Requesters 0 and 1 together; 0 re-requests and waits behind 1.
        tbl[5]  = mk(1'b1, 4'b0011, 4'b0000, 32'h0000B0A0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 4'b0011, 4'b0000, 32'h0000B0A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 4'b0011, 4'b0001, 32'h0000B0A1, 1'b1, 4'b0001, 1'b1, 8'hA1, 4'b0001, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 4'b0011, 4'b0000, 32'h0000B0C0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 4'b0011, 4'b0000, 32'h0000B0C0, 1'b1, 4'b0010, 1'b1, 8'hB0, 4'b0010, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 4'b0011, 4'b0010, 32'h0000B1C0, 1'b1, 4'b0010, 1'b1, 8'hB1, 4'b0010, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 4'b0001, 4'b0001, 32'h000000C0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 4'b0001, 4'b0001, 32'h000000C0, 1'b1, 4'b0001, 1'b1, 8'hC0, 4'b0001, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        // Backpressure 1,0,0,1 on a 4-byte packet; last coincides with the beat limit.
        tbl[14] = mk(1'b1, 4'b1010, 4'b0000, 32'hD0001000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tbl[15] = mk(1'b1, 4'b1010, 4'b0000, 32'hD0001000, 1'b1, 4'b0010, 1'b1, 8'h10, 4'b0010, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, 4'b1010, 4'b0000, 32'hD0001100, 1'b0, 4'b0010, 1'b1, 8'h11, 4'b0000, 1'b1, 1'b0);
        tbl[17] = mk(1'b1, 4'b1010, 4'b0000, 32'hD0001100, 1'b0, 4'b0010, 1'b1, 8'h11, 4'b0000, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 4'b1010, 4'b0000, 32'hD0001100, 1'b1, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1, 1'b0);
        tbl[19] = mk(1'b1, 4'b1010, 4'b0000, 32'hD0001200, 1'b1, 4'b0010, 1'b1, 8'h12, 4'b0010, 1'b1, 1'b0);
        tbl[20] = mk(1'b1, 4'b1010, 4'b0010, 32'hD0001300, 1'b1, 4'b0010, 1'b1, 8'h13, 4'b0010, 1'b1, 1'b0);
        tbl[21] = mk(1'b1, 4'b1000, 4'b1000, 32'hD0000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);
        tbl[22] = mk(1'b1, 4'b1000, 4'b1000, 32'hD0000000, 1'b1, 4'b1000, 1'b1, 8'hD0, 4'b1000, 1'b1, 1'b0);
        tbl[23] = mk(1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Beat limit: requester 1 sends 6 bytes, requester 3 waits.
        apply(mk(1'b1, 4'b1010, 4'b1000, 32'hE0005000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "burst.arb");
        for (int b = 0; b < 4; b++)
            apply(mk(1'b1, 4'b1010, 4'b1000, 32'hE0000000 | (32'(8'h50 + b) << 8), 1'b1,
                     4'b0010, 1'b1, 8'(8'h50 + b), 4'b0010, 1'b1, 1'b0), $sformatf("burst.b%0d", b));
        apply(mk(1'b1, 4'b1010, 4'b1000, 32'hE0005400, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1), "burst.forced");
        apply(mk(1'b1, 4'b1010, 4'b1000, 32'hE0005400, 1'b1, 4'b1000, 1'b1, 8'hE0, 4'b1000, 1'b1, 1'b0), "burst.req3");
        apply(mk(1'b1, 4'b0010, 4'b0000, 32'h00005400, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "burst.gap");
        apply(mk(1'b1, 4'b0010, 4'b0000, 32'h00005400, 1'b1, 4'b0010, 1'b1, 8'h54, 4'b0010, 1'b1, 1'b0), "burst.b4");
        apply(mk(1'b1, 4'b0010, 4'b0010, 32'h00005500, 1'b1, 4'b0010, 1'b1, 8'h55, 4'b0010, 1'b1, 1'b0), "burst.b5");
        apply(mk(1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "burst.end");

        // Reset after beat 2 of a 5-byte packet; requester 0 then wins.
        apply(mk(1'b1, 4'b0100, 4'b0000, 32'h00600000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "rst.arb");
        apply(mk(1'b1, 4'b0100, 4'b0000, 32'h00600000, 1'b1, 4'b0100, 1'b1, 8'h60, 4'b0100, 1'b1, 1'b0), "rst.b0");
        apply(mk(1'b1, 4'b0100, 4'b0000, 32'h00610000, 1'b1, 4'b0100, 1'b1, 8'h61, 4'b0100, 1'b1, 1'b0), "rst.b1");
        apply(mk(1'b0, 4'b0100, 4'b0000, 32'h00620000, 1'b1, 4'b0100, 1'b1, 8'h62, 4'b0100, 1'b1, 1'b0), "rst.assert");
        apply(mk(1'b1, 4'b0101, 4'b0001, 32'h00630070, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "rst.after");
        apply(mk(1'b1, 4'b0101, 4'b0001, 32'h00630070, 1'b1, 4'b0001, 1'b1, 8'h70, 4'b0001, 1'b1, 1'b0), "rst.req0");
        apply(mk(1'b1, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "rst.end");

        // Granted requester drops valid for 3 cycles; requester 0 must wait.
        apply(mk(1'b1, 4'b0011, 4'b0001, 32'h00008090, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "lock.arb");
        apply(mk(1'b1, 4'b0011, 4'b0001, 32'h00008090, 1'b1, 4'b0010, 1'b1, 8'h80, 4'b0010, 1'b1, 1'b0), "lock.b0");
        for (int c = 0; c < 3; c++)
            apply(mk(1'b1, 4'b0001, 4'b0001, 32'h00000090, 1'b1, 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0),
                  $sformatf("lock.hold%0d", c));
        apply(mk(1'b1, 4'b0011, 4'b0011, 32'h00008190, 1'b1, 4'b0010, 1'b1, 8'h81, 4'b0010, 1'b1, 1'b0), "lock.b1");
        apply(mk(1'b1, 4'b0001, 4'b0001, 32'h00000090, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "lock.gap");
        apply(mk(1'b1, 4'b0001, 4'b0001, 32'h00000090, 1'b1, 4'b0001, 1'b1, 8'h90, 4'b0001, 1'b1, 1'b0), "lock.req0");
        apply(mk(1'b0, 4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0), "lock.end");

        // Randomized traffic against the reference model (DUT freshly reset above).
        m_g = -1; m_last = NR - 1; m_cnt = 0; m_frc = 1'b0;
        for (int k = 0; k < NR; k++) begin
            cur_v[k] = 1'b0; cur_l[k] = 1'b0; cur_d[k] = 8'h00; rem[k] = 0;
        end
        n_rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NR; k++) begin
                if (!cur_v[k] && $urandom_range(0, 2) != 0) begin
                    if (rem[k] == 0) rem[k] = $urandom_range(1, 7);
                    cur_v[k] = 1'b1;
                    cur_d[k] = 8'($urandom);
                    cur_l[k] = (rem[k] == 1);
                end
                bus.i_req_valid[k]        = cur_v[k];
                bus.i_req_last[k]         = cur_l[k];
                bus.i_req_data[k*DB +: DB] = cur_d[k];
            end
            bus.i_tx_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            eg   = (m_g >= 0) ? (one << m_g) : 4'b0000;
            etxv = (m_g >= 0) ? cur_v[m_g] : 1'b0;
            erdy = bus.i_tx_ready ? eg : 4'b0000;
            chk("rnd.grant", 32'(grant), 32'(eg));
            chk("rnd.tx_valid", 32'(bus.o_tx_valid), 32'(etxv));
            chk("rnd.req_ready", 32'(bus.o_req_ready), 32'(erdy));
            chk("rnd.busy", 32'(busy), 32'(m_g >= 0));
            chk("rnd.forced", 32'(frc), 32'(m_frc));
            if (etxv) chk("rnd.tx_data", 32'(bus.o_tx_data), 32'(cur_d[m_g]));
            hs    = etxv && bus.i_tx_ready;
            m_frc = 1'b0;
            if (m_g < 0) begin
                found = 1'b0;
                for (int j = 1; j <= NR; j++) begin
                    idx = (m_last + j) % NR;
                    if (!found && cur_v[idx]) begin
                        found = 1'b1; m_g = idx; m_last = idx; m_cnt = 0;
                    end
                end
            end else if (hs) begin
                g = m_g;
                m_cnt++;
                if (cur_l[g]) m_g = -1;
                else if (m_cnt == MB) begin
                    m_g = -1; m_frc = 1'b1;
                end
                rem[g]--;
                cur_v[g] = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin packet arbiter that shares the single UART transmit path among NUM_REQ independent byte-stream requesters, such as a debug console, a bus-trace dumper and a CPU mailbox. It grants one requester at a time and holds the grant for a whole packet, delimited by last. It forwards that requester's bytes as a valid/ready stream into the UART TX FIFO write side. A beat limit forces release so that no requester can monopolise the link.

Parameters:
NUM_REQ, 4, number of requester channels (2..16)
DATA_BITS, 8, byte width; matches the UART DATA_BITS
MAX_BURST, 64, maximum beats per grant before forced release (1..65535)

Ports:
clk  in  1  system clock
n_rst  in  1  synchronous active-low reset
i_req_valid  in  NUM_REQ  per-requester beat valid
i_req_data  in  NUM_REQ*DATA_BITS  per-requester byte; requester k occupies bits [k*DATA_BITS +: DATA_BITS]
i_req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by valid
o_req_ready  out  NUM_REQ  per-requester ready
o_tx_valid  out  1  byte valid to the UART TX FIFO
o_tx_data  out  DATA_BITS  byte to the UART TX FIFO
i_tx_ready  in  1  UART TX FIFO not full
o_grant  out  NUM_REQ  one-hot current grant; all-zero when idle
o_busy  out  1  high while in GRANT
o_forced_release  out  1  one-cycle pulse when MAX_BURST ends a grant

Behaviour:
- Reset (n_rst low at a clk edge):
  - state=IDLE; o_grant=0; beat_cnt=0; last_idx=NUM_REQ-1, so requester 0 has top priority first.
  - All outputs are 0 from the following cycle.
  - Reset mid-packet drops the grant immediately; the partial packet is abandoned with no further beats.
- Handshake: a beat transfers on a cycle where o_tx_valid && i_tx_ready.
  - A requester must hold valid, data and last stable until its ready is seen.
- State IDLE:
  - o_tx_valid=0; o_req_ready=0.
  - If any i_req_valid is high, select the first valid index searching upward from last_idx+1, wrapping modulo NUM_REQ.
  - Register the selection: o_grant=onehot(sel), last_idx=sel, beat_cnt=0, state=GRANT.
  - Arbitration costs exactly 1 cycle: the first beat can transfer no earlier than the cycle after valid is sampled in IDLE.
- State GRANT, with granted index g:
  - o_tx_valid=i_req_valid[g]; o_tx_data=i_req_data[g]; o_req_ready[g]=i_tx_ready; every other ready is 0. This path is combinational, with no added latency.
  - On each handshake, beat_cnt increments. beat_cnt is saturating-safe and $clog2(MAX_BURST+1) bits wide.
  - If a handshake occurs with i_req_last[g]=1: state=IDLE, o_grant=0 next cycle.
  - Else if a handshake occurs and beat_cnt+1==MAX_BURST: state=IDLE, o_forced_release=1 for one cycle. The requester continues its packet at its next grant.
  - If last and the limit coincide: normal release, o_forced_release=0.
  - If i_req_valid[g] deasserts mid-packet, the grant is held (packet lock) with no timeout.
  - Backpressure (i_tx_ready=0): no beat transfers, beat_cnt holds, and the data path stays presented.
- After any release, the next arbitration starts from g+1, giving round-robin fairness. A lone requester is re-granted after a 1-cycle IDLE gap.
- Requests arriving from non-granted requesters during GRANT see ready=0 and wait.
- MAX_BURST=1 yields a one-byte-per-grant interleave.

Decomposition:
- Package uart_arb_pkg:
  - state enum {ARB_IDLE, ARB_GRANT}.
  - Function for the beat counter width.
  - Default MAX_BURST constant.
- Sub-module rr_priority_select: purely combinational rotating priority encoder.
  - Inputs: req[NUM_REQ], last_idx.
  - Outputs: sel index, any_req.
  - Reusable by other arbiters in the codebase.
- Top module: FSM, counter and muxing.

Test Plan:
1. Requester 2 alone sends 0x41,0x42,0x43 (last on 0x43) with i_tx_ready=1 -> o_grant=4'b0100 one cycle after valid; 3 consecutive tx beats; o_grant=0 the cycle after 0x43.
2. Requesters 0 and 1 each present a 2-byte packet in the same cycle after reset -> order is pkt0, IDLE cycle, pkt1. If req0 re-requests, it is served after req1.
3. Backpressure: i_tx_ready toggles 1,0,0,1 during a 4-byte packet -> exactly 4 handshakes; o_tx_data is stable across stalls; non-granted o_req_ready stays 0.
4. MAX_BURST=4 with requester 1 sending a 6-byte packet and requester 3 waiting -> o_forced_release pulses after beat 4; requester 3 is granted next; requester 1 resumes beats 5-6 afterward.
5. n_rst asserted after beat 2 of a 5-byte packet -> next cycle o_grant=0, o_tx_valid=0, o_busy=0. After reset, requester 0 has priority.
6. Granted requester drops valid for 3 cycles mid-packet while requester 0 is valid -> grant is held, no beats transfer, and requester 0 is not granted until last is transferred.
